// File: rtl/imm_encoder.sv
// Two-stage RV64 immediate encoder: S1 range-checks the immediate, S2 scatters
// its bits into the I/S/B fields of the base instruction word.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  ImmSrc,
    input  logic [63:0] imm,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;

    // Handshake: a word moves on any edge where valid && ready on that side;
    // valid never drops and data holds until that edge. S2 is the output register.
    logic        s1_valid;
    logic [1:0]  s1_src;
    logic [31:0] s1_base;
    logic [12:0] s1_imm;
    logic        s1_bad;

    logic        s2_adv;
    logic        s1_adv;
    logic        in_bad;
    logic        fits12;
    logic        fits13;
    logic [31:0] imm_mask;
    logic [31:0] imm_bits;
    logic [31:0] packed_word;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        fits12 = (&imm[63:11]) || !(|imm[63:11]);
        fits13 = (&imm[63:12]) || !(|imm[63:12]);
        case (ImmSrc)
            SRC_I, SRC_S: in_bad = !fits12;
            SRC_B:        in_bad = !fits13 || imm[0];
            default:      in_bad = 1'b1;
        endcase
    end

    // B-type keeps bit 11 of the immediate in instr[7] and bit 12 in instr[31].
    always_comb begin
        imm_mask = 32'h0;
        imm_bits = 32'h0;
        case (s1_src)
            SRC_I: begin
                imm_mask = MASK_I;
                imm_bits = {s1_imm[11:0], 20'b0};
            end
            SRC_S: begin
                imm_mask = MASK_SB;
                imm_bits = {s1_imm[11:5], 13'b0, s1_imm[4:0], 7'b0};
            end
            SRC_B: begin
                imm_mask = MASK_SB;
                imm_bits = {s1_imm[12], s1_imm[10:5], 13'b0, s1_imm[4:1], s1_imm[11], 7'b0};
            end
            default: begin
                imm_mask = 32'h0;
                imm_bits = 32'h0;
            end
        endcase
        packed_word = (s1_base & ~imm_mask) | (s1_bad ? 32'h0 : imm_bits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_src    <= 2'b00;
            s1_base   <= 32'h0;
            s1_imm    <= 13'h0;
            s1_bad    <= 1'b0;
            out_valid <= 1'b0;
            instr     <= 32'h0;
            err       <= 1'b0;
            err_count <= 8'h0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_src  <= ImmSrc;
                    s1_base <= base;
                    s1_imm  <= imm[12:0];
                    s1_bad  <= in_bad;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    instr <= packed_word;
                    err   <= s1_bad;
                end
            end
            if (out_valid && out_ready && err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
